// File: rtl/ball_pkg.sv
// ball_pkg: shared state, direction and default geometry for the pong datapath.
package ball_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, MISS} ball_state_t;
  typedef logic dir_t;
  localparam int DEF_MAX_X      = 640;
  localparam int DEF_MAX_Y      = 480;
  localparam int DEF_WALL_SIZE  = 16;
  localparam int DEF_BALL_SIZE  = 16;
  localparam int DEF_PADDLE_X   = 16;
  localparam int DEF_PADDLE_W   = 8;
  localparam int DEF_PADDLE_H   = 64;
  localparam int DEF_SPEED_W    = 3;
  localparam int DEF_INIT_SPEED = 1;
  localparam int DEF_MAX_SPEED  = 4;
  localparam int DEF_MISS_TICKS = 60;
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one-axis stepper that moves pos by speed and clamps/reflects at lo/hi.
module ball_axis #(
  parameter int W       = 10,
  parameter int SPEED_W = 3
) (
  input  logic [W-1:0]       pos_i,
  input  logic               dir_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic [W-1:0]       lo_i,
  input  logic [W-1:0]       hi_i,
  output logic [W-1:0]       pos_o,
  output logic               dir_o,
  output logic               at_lo_o,
  output logic               at_hi_o
);
  localparam int WE = W + 1;
  logic [W:0] sum, lim;
  assign sum     = {1'b0, pos_i} + WE'(speed_i);
  assign lim     = {1'b0, lo_i} + WE'(speed_i);
  assign at_hi_o = dir_i && sum >= {1'b0, hi_i};
  assign at_lo_o = !dir_i && {1'b0, pos_i} <= lim;
  assign pos_o   = at_hi_o ? hi_i : at_lo_o ? lo_i : dir_i ? sum[W-1:0] : pos_i - W'(speed_i);
  assign dir_o   = at_hi_o ? 1'b0 : at_lo_o ? 1'b1 : dir_i;
endmodule

// File: rtl/ball_engine.sv
// ball_engine: serve/play/miss ball motion with paddle collision and rally count.
// Define BALL_SPEEDUP_EN to raise speed by one on each paddle hit (capped at MAX_SPEED).
module ball_engine
  import ball_pkg::*;
#(
  parameter int MAX_X      = DEF_MAX_X,
  parameter int MAX_Y      = DEF_MAX_Y,
  parameter int WALL_SIZE  = DEF_WALL_SIZE,
  parameter int BALL_SIZE  = DEF_BALL_SIZE,
  parameter int PADDLE_X   = DEF_PADDLE_X,
  parameter int PADDLE_W   = DEF_PADDLE_W,
  parameter int PADDLE_H   = DEF_PADDLE_H,
  parameter int SPEED_W    = DEF_SPEED_W,
  parameter int INIT_SPEED = DEF_INIT_SPEED,
  parameter int MAX_SPEED  = DEF_MAX_SPEED,
  parameter int MISS_TICKS = DEF_MISS_TICKS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               serve,
  input  logic [9:0]         paddle_y,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               in_play,
  output logic               hit,
  output logic               miss,
  output logic [7:0]         rally,
  output logic [SPEED_W-1:0] speed
);
  localparam logic [9:0] X_MIN = 10'(PADDLE_X + PADDLE_W);
  localparam logic [9:0] X_MAX = 10'(MAX_X - WALL_SIZE - BALL_SIZE);
  localparam logic [9:0] Y_MIN = 10'(WALL_SIZE);
  localparam logic [9:0] Y_MAX = 10'(MAX_Y - WALL_SIZE - BALL_SIZE);
  localparam logic [9:0] X_C   = 10'((MAX_X - BALL_SIZE) / 2);
  localparam logic [9:0] Y_C   = 10'((MAX_Y - BALL_SIZE) / 2);
  localparam int CW = $clog2(MISS_TICKS + 1);
  localparam logic [SPEED_W-1:0] SP_INIT = SPEED_W'(INIT_SPEED);
  ball_state_t state_q;
  logic [9:0] x_q, y_q, x_d, y_d;
  dir_t dx_q, dy_q, dx_d, dy_d;
  logic in_play_q, hit_q, miss_q;
  logic [7:0] rally_q;
  logic [CW-1:0] cnt_q;
  logic x_lo, x_hi, y_lo, y_hi, overlap;
  logic unused_flags;
`ifdef BALL_SPEEDUP_EN
  logic [SPEED_W-1:0] speed_q;
  assign speed = speed_q;
`else
  assign speed = SP_INIT;
`endif
  ball_axis #(.W(10), .SPEED_W(SPEED_W)) u_x (
    .pos_i(x_q), .dir_i(dx_q), .speed_i(speed), .lo_i(X_MIN), .hi_i(X_MAX),
    .pos_o(x_d), .dir_o(dx_d), .at_lo_o(x_lo), .at_hi_o(x_hi)
  );
  ball_axis #(.W(10), .SPEED_W(SPEED_W)) u_y (
    .pos_i(y_q), .dir_i(dy_q), .speed_i(speed), .lo_i(Y_MIN), .hi_i(Y_MAX),
    .pos_o(y_d), .dir_o(dy_d), .at_lo_o(y_lo), .at_hi_o(y_hi)
  );
  // Paddle overlap uses the ball's pre-update y
  assign overlap = {1'b0, paddle_y} <= {1'b0, y_q} + 11'(BALL_SIZE - 1) &&
                   {1'b0, y_q} <= {1'b0, paddle_y} + 11'(PADDLE_H - 1);
  assign unused_flags = ^{x_hi, y_lo, y_hi, MAX_SPEED == 0};
  assign x       = x_q;
  assign y       = y_q;
  assign in_play = in_play_q;
  assign hit     = hit_q;
  assign miss    = miss_q;
  assign rally   = rally_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= X_C;
      y_q       <= Y_C;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      in_play_q <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      rally_q   <= '0;
      cnt_q     <= '0;
`ifdef BALL_SPEEDUP_EN
      speed_q   <= SP_INIT;
`endif
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE: if (serve) begin
          state_q   <= PLAY;
          in_play_q <= 1'b1;
          rally_q   <= '0;
        end
        PLAY: if (tick) begin
          y_q  <= y_d;
          dy_q <= dy_d;
          if (x_lo && overlap) begin
            x_q     <= X_MIN;
            dx_q    <= 1'b1;
            hit_q   <= 1'b1;
            rally_q <= rally_q == 8'hFF ? rally_q : rally_q + 8'd1;
`ifdef BALL_SPEEDUP_EN
            speed_q <= speed_q < SPEED_W'(MAX_SPEED) ? speed_q + 1'b1 : speed_q;
`endif
          end else if (x_lo) begin
            x_q       <= '0;
            miss_q    <= 1'b1;
            cnt_q     <= CW'(MISS_TICKS);
            state_q   <= MISS;
            in_play_q <= 1'b0;
          end else begin
            x_q  <= x_d;
            dx_q <= dx_d;
          end
        end
        MISS: if (tick) begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            x_q     <= X_C;
            y_q     <= Y_C;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
`ifdef BALL_SPEEDUP_EN
            speed_q <= SP_INIT;
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          in_play_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed checks of ball_engine against hand values and a small trajectory model.
module tb_ball_engine;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, serve = 1'b0;
  logic [9:0] paddle_y = '0, x, y;
  logic in_play, hit, miss;
  logic [7:0] rally;
  logic [2:0] speed;
  int n_chk = 0, n_pass = 0;
  int mx, my, mdx, mdy, msp, mr, mst, mcnt, mhit, mmiss;
`ifdef BALL_SPEEDUP_EN
  localparam int SPEEDUP = 1;
`else
  localparam int SPEEDUP = 0;
`endif
  ball_engine dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .serve(serve), .paddle_y(paddle_y),
    .x(x), .y(y), .in_play(in_play), .hit(hit), .miss(miss), .rally(rally), .speed(speed)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic model_park();
    mx = 312; my = 232; mdx = 1; mdy = 1; msp = 1;
  endtask
  task automatic model_edge(input bit t, input bit s, input int py);
    int oy;
    mhit = 0; mmiss = 0; oy = my;
    if (mst == 0 && s) begin mst = 1; mr = 0; end
    else if (mst == 1 && t) begin
      if (mdy == 1) begin
        if (my + msp >= 448) begin my = 448; mdy = 0; end else my = my + msp;
      end else if (my <= 16 + msp) begin my = 16; mdy = 1; end
      else my = my - msp;
      if (mdx == 1) begin
        if (mx + msp >= 608) begin mx = 608; mdx = 0; end else mx = mx + msp;
      end else if (mx <= 24 + msp) begin
        if (py <= oy + 15 && oy <= py + 63) begin
          mx = 24; mdx = 1; mhit = 1;
          if (mr < 255) mr++;
          if (SPEEDUP == 1 && msp < 4) msp++;
        end else begin mx = 0; mmiss = 1; mcnt = 60; mst = 2; end
      end else mx = mx - msp;
    end else if (mst == 2 && t) begin
      if (mcnt == 1) begin mst = 0; model_park(); end
      mcnt--;
    end
  endtask
  task automatic cyc(input bit t, input bit s, input int py);
    tick = t; serve = s; paddle_y = 10'(py);
    @(posedge clk);
    model_edge(t, s, py);
    #1;
    tick = 1'b0; serve = 1'b0;
  endtask
  task automatic track();
    check("pos", {x, y}, (mx << 10) | my);
    check("flags", {in_play, hit, miss}, ((mst == 1) << 2) | (mhit << 1) | mmiss);
    check("rally", rally, mr);
    check("speed", speed, msp);
  endtask
  initial begin
    model_park(); mr = 0; mst = 0; mcnt = 0; mhit = 0; mmiss = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    check("rst_x", x, 312); check("rst_y", y, 232); check("rst_in_play", in_play, 0);
    check("rst_speed", speed, 1); check("rst_hm", {hit, miss}, 0); check("rst_rally", rally, 0);
    cyc(1, 1, 0);
    check("serve_tick_x", x, 312); check("serve_tick_y", y, 232); check("serve_in_play", in_play, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    check("ten_x", x, 322); check("ten_y", y, 242);
    for (int i = 0; i < 205; i++) cyc(1, 0, 0);
    check("near_bottom_y", y, 447);
    cyc(1, 0, 0); check("bottom_clamp_y", y, 448);
    cyc(1, 0, 0); check("bottom_reflect_y", y, 447);
    for (int i = 0; i < 3000 && mhit == 0; i++) begin cyc(1, 0, my); track(); end
    check("first_hit_seen", mhit, 1);
    check("hit_x", x, 24); check("hit_pulse", hit, 1); check("hit_rally", rally, 1);
    check("hit_speed", speed, SPEEDUP == 1 ? 2 : 1);
    cyc(1, 0, my); track();
    check("hit_one_cycle", hit, 0); check("hit_dx_right", x, SPEEDUP == 1 ? 26 : 25);
    for (int i = 0; i < 12000 && mr < 6; i++) begin cyc(1, 0, my); track(); end
    check("six_hits_rally", rally, 6);
    check("six_hits_speed", speed, SPEEDUP == 1 ? 4 : 1);
    for (int i = 0; i < 3000 && mmiss == 0; i++) begin cyc(1, 0, my >= 100 ? 0 : 400); track(); end
    check("miss_pulse", miss, 1); check("miss_x", x, 0); check("miss_in_play", in_play, 0);
    cyc(1, 1, 0); track();
    check("miss_one_cycle", miss, 0); check("serve_in_miss", in_play, 0); check("miss_frozen_x", x, 0);
    for (int i = 0; i < 58; i++) cyc(1, 0, 0);
    check("miss_still_frozen", x, 0);
    cyc(1, 0, 0);
    check("idle_x", x, 312); check("idle_y", y, 232); check("idle_speed", speed, 1);
    check("idle_rally_kept", rally, 6); check("idle_in_play", in_play, 0);
    cyc(0, 1, 0); check("serve_clears_rally", rally, 0); check("replay", in_play, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    check("replay_x", x, 317);
    rst_n = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; rst_n = 1'b1;
    check("midplay_rst_x", x, 312); check("midplay_rst_y", y, 232);
    check("midplay_rst_in_play", in_play, 0); check("midplay_rst_speed", speed, 1);
    check("midplay_rst_hm", {hit, miss}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball motion engine for the pong datapath. It generalises the free-running bouncing ball with configurable playfield and ball geometry, multi-pixel speed, and frame-tick pacing. It adds a serve/play/miss state machine with paddle collision on the left edge, and reports hit/miss events and a rally count. The block sits between the paddle controller (which drives `paddle_y`) and the renderer/scorer (which consume `x`, `y` and the event pulses).

## Interface
- `MAX_X`, 640: playfield width, in pixels.
- `MAX_Y`, 480: playfield height, in pixels.
- `WALL_SIZE`, 16: thickness of the top, bottom and right walls.
- `BALL_SIZE`, 16: ball square edge length.
- `PADDLE_X`, 16: left edge of the paddle.
- `PADDLE_W`, 8: paddle width.
- `PADDLE_H`, 64: paddle height.
- `SPEED_W`, 3: width of the speed magnitude.
- `INIT_SPEED`, 1: speed in pixels per tick after serve and after reset.
- `MAX_SPEED`, 4: speed ceiling. Constraint: 1 ≤ INIT_SPEED ≤ MAX_SPEED < 2^SPEED_W and MAX_SPEED < WALL_SIZE.
- `MISS_TICKS`, 60: number of ticks spent in MISS before returning to IDLE.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `tick` in 1: frame strobe; the ball advances once per tick.
- `serve` in 1: start a rally. Only honoured in IDLE.
- `paddle_y` in 10: paddle top edge, sampled on tick cycles.
- `x` out 10: ball top-left x.
- `y` out 10: ball top-left y.
- `in_play` out 1: high while the state is PLAY.
- `hit` out 1: one-cycle pulse on a paddle bounce.
- `miss` out 1: one-cycle pulse when the ball passes the paddle.
- `rally` out 8: paddle hits in the current rally; saturates at 255.
- `speed` out SPEED_W: current speed magnitude.

## Operation
Derived bounds (all unsigned 10-bit):
- X_MIN = PADDLE_X + PADDLE_W.
- X_MAX = MAX_X − WALL_SIZE − BALL_SIZE.
- Y_MIN = WALL_SIZE.
- Y_MAX = MAX_Y − WALL_SIZE − BALL_SIZE.
- X_C = (MAX_X − BALL_SIZE)/2.
- Y_C = (MAX_Y − BALL_SIZE)/2.

Velocity is held as direction bits (`dx`: 1 = right, `dy`: 1 = down) plus a shared magnitude `speed`. Positions never underflow and never overshoot a bound.

States:
- **IDLE**: the ball is parked at (X_C, Y_C) with dx = 1, dy = 1 and speed = INIT_SPEED. `serve` → PLAY on the next cycle and clears `rally`. `tick` is ignored.
- **PLAY**: on each tick, the Y axis and the X axis update independently, in the same tick.
  - Y, moving down: if y + speed ≥ Y_MAX, set y = Y_MAX and dy = 0.
  - Y, moving up: if y ≤ Y_MIN + speed, set y = Y_MIN and dy = 1.
  - Y, otherwise: y ± speed.
  - X, moving right: if x + speed ≥ X_MAX, set x = X_MAX and dx = 0.
  - X, moving left with x ≤ X_MIN + speed: test the paddle overlap, paddle_y ≤ y + BALL_SIZE − 1 AND y ≤ paddle_y + PADDLE_H − 1. The test uses the pre-update y.
    - Overlap → x = X_MIN, dx = 1, pulse `hit`, rally += 1 (saturating), and speed-up per Configuration.
    - No overlap → x = 0, pulse `miss`, load the MISS counter with MISS_TICKS, state = MISS.
  - X, otherwise: x ± speed.
- **MISS**: the ball stays frozen. Each tick decrements the counter. The tick that sees the counter at 1 returns the state to IDLE with the IDLE park values. `serve` is ignored.

## Timing
- All outputs are registered. A tick sampled at edge N is reflected in `x`, `y`, `hit`, `miss`, `rally` and `speed` after edge N.
- `hit` and `miss` are high for exactly one cycle.
- Reset values:
  - x = X_C, y = Y_C.
  - State IDLE, so in_play = 0.
  - hit = 0, miss = 0, rally = 0.
  - speed = INIT_SPEED, dx = 1, dy = 1.
  - MISS counter = 0.
- Reset mid-rally or mid-MISS overrides everything in the same edge.
- `serve` and `tick` together in IDLE: the block enters PLAY and does not move that cycle.
- A corner case (Y bounce and X bounce on the same tick) applies both reflections in that tick.
- A hit on the same tick as a top/bottom bounce is legal.

## Configuration
- `BALL_SPEEDUP_EN` defined: each paddle hit sets speed = min(speed + 1, MAX_SPEED).
- `BALL_SPEEDUP_EN` undefined: speed is constant at INIT_SPEED, and `speed` is a tied constant.
- `rally` counting is unaffected by the macro.

## Structure
- Package `ball_pkg` holds:
  - the state enum `ball_state_t` (IDLE, PLAY, MISS);
  - the direction typedef;
  - the default geometry localparams, shared with the renderer and paddle blocks.
- Sub-module `ball_axis`: a one-axis clamp/reflect stepper.
  - Inputs: pos, dir, speed, lo, hi.
  - Outputs: next pos, next dir, `at_lo`, `at_hi`.
  - Instantiated for Y directly.
  - For X, the top level overrides the `at_lo` outcome with the paddle/miss decision.

## Test plan
- Reset with defaults → x = 312, y = 232, in_play = 0, speed = 1. Then serve plus 10 ticks → x = 322, y = 242.
- Ball at y = 447 moving down, speed 1, tick → y = 448 and dy = 0. Next tick → y = 447.
- Ball at x = 25 moving left, paddle_y = y, tick → x = 24, dx = 1, one-cycle hit, rally = 1. With BALL_SPEEDUP_EN, speed = 2.
- Ball at x = 25 moving left, y = 232, paddle_y = 400, tick → miss pulse, x = 0, state MISS. After 60 ticks → IDLE at (312, 232) with speed 1.
- Six consecutive hits with BALL_SPEEDUP_EN → speed saturates at 4. Without the macro → speed stays 1 and rally = 6.
- Assert rst_n low during PLAY with tick high → the next cycle shows the reset values. Serve in MISS → ignored.
